mips_controller: RTL and testbench
==================================

// Module: mips_controller
// PURPOSE
//  Multicycle control FSM for the 8-bit MIPS core. It sits directly upstream of the datapath:
//  consumes op/funct/zero from it and drives every datapath select/enable plus memory read/write strobes.
//  Fetches a 32-bit instruction as 4 byte reads, then sequences LB, SB, R-type, BEQ, J, ADDI.
//  Includes ALU-control decode (aluop + funct -> alucont).
// PARAMETERS
//  none (encodings fixed in mips_defs package)
// PORTS
//  clk        in   1  system clock; single clock domain, all state updates on posedge
//  reset      in   1  synchronous, active-high reset
//  op         in   6  instr[31:26] from datapath
//  funct      in   6  instr[5:0] from datapath
//  zero       in   1  ALU zero flag from datapath (combinational, same cycle)
//  memread    out  1  memory read strobe
//  memwrite   out  1  memory write strobe
//  pcen       out  1  PC register enable = pcwrite | (pcwritecond & zero)
//  iord       out  1  address mux: 0=PC, 1=ALU result
//  irwrite    out  4  one-hot instruction-byte load enable, bit n loads instr[8n+7:8n]
//  regdst     out  1  write-reg mux: 0=instr[20:16], 1=instr[15:11]
//  memtoreg   out  1  write-data mux: 0=ALU, 1=memory data reg
//  regwrite   out  1  register file write enable
//  alusrca    out  1  ALU A: 0=PC, 1=reg A
//  alusrcb    out  2  ALU B: 00=reg B, 01=const 1, 10=imm, 11=imm<<2
//  alucont    out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  pcsource   out  2  00=ALU, 01=ALUOut reg, 10=jump target imm<<2
//  state      out  4  current FSM state (debug/verification)
// BEHAVIOUR
//  - Moore FSM; all outputs decode from state only, except pcen (uses zero) and alucont (uses funct in RTYPEEX).
//  - Unlisted outputs are 0 in each state. aluop: add=00, sub=01, funct=10.
//  - FETCH1..4: memread=1, iord=0, irwrite=0001/0010/0100/1000, alusrca=0, alusrcb=01, add,
//    pcwrite=1, pcsource=00. FETCH1->2->3->4->DECODE.
//  - DECODE: alusrca=0, alusrcb=11, add (branch target latched into ALUOut).
//    Next state by op: LB 100000 / SB 101000 -> MEMADR; RTYPE 000000 -> RTYPEEX;
//    BEQ 000100 -> BEQEX; J 000010 -> JEX; ADDI 001000 -> ADDIEX.
//    Any other op -> FETCH1 (treated as NOP; no writes).
//  - MEMADR: alusrca=1, alusrcb=10, add. LB -> LBRD, SB -> SBWR.
//  - LBRD: memread=1, iord=1 -> LBWR.
//  - LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
//  - SBWR: memwrite=1, iord=1 -> FETCH1.
//  - RTYPEEX: alusrca=1, alusrcb=00, aluop=funct -> RTYPEWR.
//  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
//  - BEQEX: alusrca=1, alusrcb=00, sub, pcwritecond=1, pcsource=01 -> FETCH1.
//  - JEX: pcwrite=1, pcsource=10 -> FETCH1.
//  - ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWR.
//  - ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH1.
//  - alu_control: aluop 00->010, 01->110; aluop 10 uses funct:
//    100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
//  - Cycles per instruction: LB 8; SB/R/ADDI 7; BEQ/J 6; unknown op 5.
//  - Reset: a clock edge with reset=1 sets state to FETCH1, asserted at any point including mid-instruction.
//    While reset=1, pcen, regwrite, memwrite and irwrite are forced to 0 and memread=0,
//    so an aborted instruction leaves no architectural side effects.
//  - Unreachable state encodings -> FETCH1 on the next edge; all write enables are 0 meanwhile.
// STRUCTURE
//  - Package mips_defs: opcode and funct localparams, state encodings (4-bit), aluop and alucont codes.
//  - Sub-module alu_control (combinational aluop/funct -> alucont); the FSM stays in mips_controller.
// TESTING
//  - reset=1 for 3 cycles -> state=FETCH1, pcen=regwrite=memwrite=0, irwrite=0000; release -> FETCH1 outputs.
//  - Fetch: 4 cycles -> irwrite 0001,0010,0100,1000; pcen=1, alusrcb=01 each; then DECODE with alusrcb=11.
//  - op=000000, funct=101010 -> RTYPEEX alucont=111; RTYPEWR regwrite=1, regdst=1; back to FETCH1 after 7 cycles.
//  - op=000100: zero=1 in BEQEX -> pcen=1, pcsource=01; zero=0 -> pcen=0; both -> FETCH1 next.
//  - op=100000 -> MEMADR, LBRD (memread=1, iord=1), LBWR (regwrite=1, memtoreg=1); op=101000 -> SBWR memwrite=1.
//  - op=111111 -> DECODE->FETCH1, no write; reset asserted in LBRD -> FETCH1 next edge, regwrite never 1.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes, ALU codes,
// FSM state encoding and the per-state control word.
package mips_defs;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch1  = 4'd0,
    StFetch2  = 4'd1,
    StFetch3  = 4'd2,
    StFetch4  = 4'd3,
    StDecode  = 4'd4,
    StMemAdr  = 4'd5,
    StLbRd    = 4'd6,
    StLbWr    = 4'd7,
    StSbWr    = 4'd8,
    StRtypeEx = 4'd9,
    StRtypeWr = 4'd10,
    StBeqEx   = 4'd11,
    StJEx     = 4'd12,
    StAddiEx  = 4'd13,
    StAddiWr  = 4'd14
  } state_e;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  // Moore control word for each state; anything not set stays 0 (aluop 00 = add).
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch1, StFetch2, StFetch3, StFetch4: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
        c.aluop   = AluOpAdd;
        case (s)
          StFetch1: c.irwrite = 4'b0001;
          StFetch2: c.irwrite = 4'b0010;
          StFetch3: c.irwrite = 4'b0100;
          default:  c.irwrite = 4'b1000;
        endcase
      end
      StDecode: c.alusrcb = 2'b11;
      StMemAdr: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      StLbRd: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      StLbWr: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      StSbWr: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      StRtypeEx: begin
        c.alusrca = 1'b1;
        c.aluop   = AluOpFunct;
      end
      StRtypeWr: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      StBeqEx: begin
        c.alusrca     = 1'b1;
        c.aluop       = AluOpSub;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      StJEx: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      StAddiEx: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      StAddiWr: c.regwrite = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_controller_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       pcen;
  logic       iord;
  logic [3:0] irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucont;
  logic [1:0] pcsource;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, pcen, iord, irwrite, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, alucont, pcsource, state
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, pcen, iord, irwrite, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, alucont, pcsource, state
  );
endinterface

// File: rtl/alu_control.sv
// Combinational ALU control decode: aluop selects add/sub directly or defers to funct.
module alu_control
  import mips_defs::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucont
);

  always_comb begin
    o_alucont = AluAdd;
    case (i_aluop)
      AluOpAdd: o_alucont = AluAdd;
      AluOpSub: o_alucont = AluSub;
      AluOpFunct: begin
        case (i_funct)
          FunctAdd: o_alucont = AluAdd;
          FunctSub: o_alucont = AluSub;
          FunctAnd: o_alucont = AluAnd;
          FunctOr:  o_alucont = AluOr;
          FunctSlt: o_alucont = AluSlt;
          default:  o_alucont = AluAdd;
        endcase
      end
      default: o_alucont = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS core: 4-byte fetch, decode, then per-opcode
// execute/writeback. Control word is registered alongside the state.
module mips_controller
  import mips_defs::*;
(
  input  logic               clk,
  input  logic               reset,
  mips_controller_if.master  bus
);

  state_e     r_state;
  state_e     w_state_next;
  ctrl_t      r_ctrl;
  logic [2:0] w_alucont;

  always_comb begin
    w_state_next = StFetch1;
    case (r_state)
      StFetch1: w_state_next = StFetch2;
      StFetch2: w_state_next = StFetch3;
      StFetch3: w_state_next = StFetch4;
      StFetch4: w_state_next = StDecode;
      StDecode: begin
        case (bus.op)
          OpLb, OpSb: w_state_next = StMemAdr;
          OpRtype:    w_state_next = StRtypeEx;
          OpBeq:      w_state_next = StBeqEx;
          OpJ:        w_state_next = StJEx;
          OpAddi:     w_state_next = StAddiEx;
          default:    w_state_next = StFetch1;
        endcase
      end
      StMemAdr:  w_state_next = (bus.op == OpSb) ? StSbWr : StLbRd;
      StLbRd:    w_state_next = StLbWr;
      StRtypeEx: w_state_next = StRtypeWr;
      StAddiEx:  w_state_next = StAddiWr;
      default:   w_state_next = StFetch1;
    endcase
  end

  // Control word tracks the state it belongs to, so outputs stay pure Moore but glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch1;
      r_ctrl  <= state_ctrl(StFetch1);
    end else begin
      r_state <= w_state_next;
      r_ctrl  <= state_ctrl(w_state_next);
    end
  end

  alu_control u_alu_control (
    .i_aluop   (r_ctrl.aluop),
    .i_funct   (bus.funct),
    .o_alucont (w_alucont)
  );

  // Reset masks every architectural side effect within the same cycle it is asserted.
  assign bus.pcen     = ~reset & (r_ctrl.pcwrite | (r_ctrl.pcwritecond & bus.zero));
  assign bus.memread  = ~reset & r_ctrl.memread;
  assign bus.memwrite = ~reset & r_ctrl.memwrite;
  assign bus.regwrite = ~reset & r_ctrl.regwrite;
  assign bus.irwrite  = reset ? 4'b0000 : r_ctrl.irwrite;
  assign bus.iord     = r_ctrl.iord;
  assign bus.regdst   = r_ctrl.regdst;
  assign bus.memtoreg = r_ctrl.memtoreg;
  assign bus.alusrca  = r_ctrl.alusrca;
  assign bus.alusrcb  = r_ctrl.alusrcb;
  assign bus.pcsource = r_ctrl.pcsource;
  assign bus.alucont  = w_alucont;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller: directed cases plus random instruction stream
// compared cycle by cycle against an instruction-level reference model.
module tb_mips_controller;
  import mips_defs::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       mw;
    logic       pcen;
    logic       iord;
    logic [3:0] irw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] ac;
    logic [1:0] ps;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mips_controller_if bus ();

  mips_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one step of an instruction, straight from the per-step rules.
  function automatic obs_t expect_out(input state_e s, input logic [5:0] f, input logic z,
                                      input logic rst);
    obs_t e;
    e    = '0;
    e.st = s;
    e.ac = 3'b010;
    case (s)
      StFetch1: begin e.mr = 1; e.pcen = 1; e.asb = 2'b01; e.irw = 4'b0001; end
      StFetch2: begin e.mr = 1; e.pcen = 1; e.asb = 2'b01; e.irw = 4'b0010; end
      StFetch3: begin e.mr = 1; e.pcen = 1; e.asb = 2'b01; e.irw = 4'b0100; end
      StFetch4: begin e.mr = 1; e.pcen = 1; e.asb = 2'b01; e.irw = 4'b1000; end
      StDecode:  e.asb = 2'b11;
      StMemAdr:  begin e.asa = 1; e.asb = 2'b10; end
      StLbRd:    begin e.mr = 1; e.iord = 1; end
      StLbWr:    begin e.rw = 1; e.m2r = 1; end
      StSbWr:    begin e.mw = 1; e.iord = 1; end
      StRtypeEx: begin e.asa = 1; e.ac = ref_alu(f); end
      StRtypeWr: begin e.rw = 1; e.rd = 1; end
      StBeqEx:   begin e.asa = 1; e.ac = 3'b110; e.pcen = z; e.ps = 2'b01; end
      StJEx:     begin e.pcen = 1; e.ps = 2'b10; end
      StAddiEx:  begin e.asa = 1; e.asb = 2'b10; end
      StAddiWr:  e.rw = 1;
      default: ;
    endcase
    if (rst) begin
      e.mr = 0; e.mw = 0; e.pcen = 0; e.rw = 0; e.irw = 4'b0000;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    return obs_t'({bus.state, bus.memread, bus.memwrite, bus.pcen, bus.iord, bus.irwrite,
                   bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb,
                   bus.alucont, bus.pcsource});
  endfunction

  function automatic bit is_known(input logic [5:0] op);
    return op inside {OpRtype, OpLb, OpSb, OpBeq, OpJ, OpAddi};
  endfunction

  // zmode: 0/1 force zero, 2 random. rst_step: step index at which reset is held (-1 none).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                           input int rst_step);
    state_e seq[$];
    obs_t   exp;
    seq = '{StFetch1, StFetch2, StFetch3, StFetch4, StDecode};
    case (op)
      OpLb:    begin seq.push_back(StMemAdr); seq.push_back(StLbRd); seq.push_back(StLbWr); end
      OpSb:    begin seq.push_back(StMemAdr); seq.push_back(StSbWr); end
      OpRtype: begin seq.push_back(StRtypeEx); seq.push_back(StRtypeWr); end
      OpBeq:   seq.push_back(StBeqEx);
      OpJ:     seq.push_back(StJEx);
      OpAddi:  begin seq.push_back(StAddiEx); seq.push_back(StAddiWr); end
      default: ;
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      @(negedge clk);
      reset     = (k == rst_step);
      bus.zero  = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      bus.op    = (k >= 4) ? op : 6'($urandom);
      bus.funct = (k >= 4) ? f : 6'($urandom);
      #1;
      exp = expect_out(seq[k], bus.funct, bus.zero, reset);
      check($sformatf("op=%b step=%0d rst=%0b", op, k, reset), 32'(sample()), 32'(exp));
      if (reset) break;
    end
  endtask

  logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] ops[6]    = '{OpLb, OpSb, OpRtype, OpBeq, OpJ, OpAddi};

  initial begin
    logic [5:0] op;
    logic [5:0] f;
    int         rs;

    reset     = 1'b1;
    bus.op    = '0;
    bus.funct = '0;
    bus.zero  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_hold", 32'(sample()), 32'(expect_out(StFetch1, bus.funct, 1'b1, 1'b1)));
    end

    run_instr(OpRtype, 6'b101010, 2, -1);
    run_instr(OpBeq, 6'b000000, 1, -1);
    run_instr(OpBeq, 6'b000000, 0, -1);
    run_instr(OpLb, 6'b000000, 2, -1);
    run_instr(OpSb, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(OpLb, 6'b000000, 2, 6);
    run_instr(OpJ, 6'b000000, 2, -1);
    run_instr(OpAddi, 6'b000000, 2, -1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 6) == 6) begin
        do op = 6'($urandom); while (is_known(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, f, 2, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
